rdb_pair_arb: RTL and testbench
===============================

RDB_PAIR_ARB -- requirements
Module: rdb_pair_arb

Interface
REQ-001 Parameter NUM_PAIR, default 4, SHALL set the number of channel pairs; the input channel count SHALL be 2*NUM_PAIR.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set per-channel holding FIFO entries; legal values are powers of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_vld  input  2*NUM_PAIR  SHALL be per-channel data valid, one beat per cycle, with no backpressure; channel 2i and channel 2i+1 form pair i.
REQ-006 in_pld  input  group_data_pld_t [2*NUM_PAIR]  SHALL be the per-channel payload, sampled only when in_vld is set.
REQ-007 out_vld  output  NUM_PAIR  SHALL be the per-pair valid toward the RDB.
REQ-008 out_pld  output  group_data_pld_t [NUM_PAIR]  SHALL be the per-pair payload toward the RDB.
REQ-009 out_rdy  input  NUM_PAIR  SHALL be the RDB ready; a beat transfers when out_vld and out_rdy are both high.
REQ-010 ovf_err  output  2*NUM_PAIR  SHALL be a sticky per-channel overflow flag.
REQ-011 err_clr  input  1  SHALL be a synchronous clear of all ovf_err bits.
REQ-012 idle  output  1  SHALL be high when all FIFOs are empty and all out_vld bits are low.
REQ-013 collision_cnt  output  16*NUM_PAIR  SHALL be a per-pair count of simultaneous-valid cycles (see REQ-029).

Function
REQ-014 Each channel SHALL own one FIFO_DEPTH-entry FIFO; in_vld SHALL push in_pld at the rising edge.
REQ-015 Push while full SHALL drop the beat and set ovf_err for that channel, unless the same edge pops that FIFO; push+pop at full SHALL be lossless.
REQ-016 Per pair, the output stage SHALL be one register (out_vld/out_pld), loadable when out_vld is low or out_rdy is high.
REQ-017 When loadable and at least one FIFO of the pair is non-empty, the arbiter SHALL pop one head into the output register at that edge.
REQ-018 Grant rule: if both FIFOs are non-empty, grant the channel selected by a 1-bit rr_ptr per pair; if only one is non-empty, grant that channel.
REQ-019 After every grant, rr_ptr SHALL point to the non-granted channel; with no grant, rr_ptr SHALL hold.
REQ-020 If out_vld is high and out_rdy is low, out_vld and out_pld SHALL hold stable and no pop SHALL occur.
REQ-021 Latency: a beat pushed at edge E0 into an empty pair with an empty or accepting output SHALL appear on out_vld after edge E1 (2-cycle in-to-out).
REQ-022 Sustained throughput SHALL be one beat per cycle per pair while out_rdy is high.
REQ-023 Beats from one channel SHALL leave in arrival order; interleaving between the two channels of a pair is governed only by REQ-018.
REQ-024 A pop into an emptying output (transfer and reload at the same edge) SHALL produce back-to-back beats with no bubble.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits with wrap; full is defined as pointers equal except the MSB.
REQ-026 err_clr SHALL clear ovf_err; an overflow at the same edge as err_clr SHALL leave ovf_err set (set wins).
REQ-027 Pairs SHALL be fully independent; there SHALL be no cross-pair arbitration.

Reset
REQ-028 On rst: out_vld=0, out_pld=0, all FIFOs empty, rr_ptr=0 (channel 2i preferred), ovf_err=0, collision_cnt=0, idle=1; reset asserted mid-transfer SHALL discard all buffered beats.

Configuration
REQ-029 With macro RDB_PAIR_ARB_COLLISION_CNT_EN defined, each pair SHALL count cycles where in_vld[2i] and in_vld[2i+1] are both high, in a 16-bit counter that saturates at 0xFFFF and is cleared by rst or err_clr.
REQ-030 Without RDB_PAIR_ARB_COLLISION_CNT_EN, collision_cnt SHALL be tied to 0 and the counters SHALL not be synthesized; all other behaviour is identical.

Verification
REQ-031 Single beat: after reset, in_vld[0]=1 with pld A for one cycle, out_rdy=1 -> out_vld[0]=1, out_pld[0]=A two cycles after the input, for exactly one cycle; idle returns to 1.
REQ-032 Collision: in_vld[2]=in_vld[3]=1 with B and C in the same cycle, out_rdy=1 -> pair 1 outputs B then C on consecutive cycles; rr_ptr ends at 0; collision_cnt[1]=1 when enabled, else 0.
REQ-033 Backpressure: out_rdy[0]=0, push 3 beats on channel 0 with FIFO_DEPTH=2 -> output holds beat 1; beats 2 and 3 are buffered; no overflow. A 4th push sets ovf_err[0]=1, that beat is dropped, and the other beats are delivered in order once out_rdy rises.
REQ-034 Fairness: channels 4 and 5 are both pushed every cycle for 8 cycles with out_rdy=1 -> pair 2 alternates 4,5,4,5 with no starvation; overflows occur as REQ-015 predicts.
REQ-035 Reset mid-operation: rst asserted while pair 3 holds 2 buffered beats and out_vld[3]=1 -> out_vld drops immediately (asynchronously), and no stale beat appears after reset release.
REQ-036 Error clear: ovf_err[1]=1, then pulse err_clr -> ovf_err[1]=0; err_clr coincident with a new overflow on channel 1 -> ovf_err[1] stays 1.

Source files
------------

// File: rtl/rdb_pair_arb.sv
// Per-pair round-robin arbiter feeding the RDB: each channel buffers beats in a small FIFO,
// each pair merges its two channels into one registered output. Optional macro: RDB_PAIR_ARB_COLLISION_CNT_EN.
package rdb_pair_arb_pkg;
   typedef logic [31:0] group_data_pld_t;
endpackage

module rdb_pair_arb
   import rdb_pair_arb_pkg::*;
#(
   parameter int unsigned NUM_PAIR   = 4,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*NUM_PAIR-1:0]   in_vld,
   input  group_data_pld_t         in_pld [2*NUM_PAIR],
   output logic [NUM_PAIR-1:0]     out_vld,
   output group_data_pld_t         out_pld [NUM_PAIR],
   input  logic [NUM_PAIR-1:0]     out_rdy,
   output logic [2*NUM_PAIR-1:0]   ovf_err,
   input  logic                    err_clr,
   output logic                    idle,
   output logic [16*NUM_PAIR-1:0]  collision_cnt
);

   localparam int unsigned NUM_CH = 2 * NUM_PAIR;
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned PW     = AW + 1;
   localparam logic [PW-1:0] PTR_MSB = PW'(1) << AW;

   group_data_pld_t        mem  [NUM_CH][FIFO_DEPTH];
   group_data_pld_t        head [NUM_CH];
   logic [PW-1:0]          wr_ptr [NUM_CH];
   logic [PW-1:0]          rd_ptr [NUM_CH];
   logic [NUM_CH-1:0]      empty;
   logic [NUM_CH-1:0]      full;
   logic [NUM_CH-1:0]      pop;
   logic [NUM_CH-1:0]      accept;
   logic [NUM_CH-1:0]      ovf_set;
   logic [NUM_PAIR-1:0]    rr_ptr;
   logic [NUM_PAIR-1:0]    grant;
   logic [NUM_PAIR-1:0]    grant_hi;

   // FIFO status: full when pointers differ only in the wrap bit
   always_comb begin
      empty = '0;
      full  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         empty[c] = (wr_ptr[c] == rd_ptr[c]);
         full[c]  = ((wr_ptr[c] ^ rd_ptr[c]) == PTR_MSB);
         head[c]  = mem[c][rd_ptr[c][AW-1:0]];
      end
   end

   // Arbitration: rr_ptr only matters when both heads compete
   always_comb begin
      grant    = '0;
      grant_hi = '0;
      pop      = '0;
      for (int unsigned p = 0; p < NUM_PAIR; p++) begin
         grant[p]    = (!out_vld[p] || out_rdy[p]) && !(empty[2*p] && empty[2*p+1]);
         grant_hi[p] = empty[2*p] || (!empty[2*p+1] && rr_ptr[p]);
         pop[2*p]    = grant[p] && !grant_hi[p];
         pop[2*p+1]  = grant[p] && grant_hi[p];
      end
   end

   // A push into a full FIFO survives only if the same edge pops it
   always_comb begin
      accept  = '0;
      ovf_set = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         accept[c]  = in_vld[c] && (!full[c] || pop[c]);
         ovf_set[c] = in_vld[c] && full[c] && !pop[c];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (accept[c]) begin
            mem[c][wr_ptr[c][AW-1:0]] <= in_pld[c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
         ovf_err <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (accept[c]) begin
               wr_ptr[c] <= wr_ptr[c] + PW'(1);
            end
            if (pop[c]) begin
               rd_ptr[c] <= rd_ptr[c] + PW'(1);
            end
         end
         // set wins over a coincident clear
         ovf_err <= ovf_set | (ovf_err & ~{NUM_CH{err_clr}});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         out_vld <= '0;
         for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            out_pld[p] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            if (grant[p]) begin
               out_vld[p] <= 1'b1;
               out_pld[p] <= grant_hi[p] ? head[2*p+1] : head[2*p];
               rr_ptr[p]  <= ~grant_hi[p];
            end else if (out_rdy[p]) begin
               out_vld[p] <= 1'b0;
            end
         end
      end
   end

   assign idle = (&empty) && !(|out_vld);

`ifdef RDB_PAIR_ARB_COLLISION_CNT_EN
   logic [15:0] coll_q [NUM_PAIR];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            coll_q[p] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            if (err_clr) begin
               coll_q[p] <= '0;
            end else if (in_vld[2*p] && in_vld[2*p+1] && (coll_q[p] != '1)) begin
               coll_q[p] <= coll_q[p] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      collision_cnt = '0;
      for (int unsigned p = 0; p < NUM_PAIR; p++) begin
         collision_cnt[16*p +: 16] = coll_q[p];
      end
   end
`else
   assign collision_cnt = '0;
`endif

endmodule

// File: tb/tb_rdb_pair_arb.sv
// Directed bench for rdb_pair_arb: vector table for single beat, collision, backpressure
// and error clear, plus hand sequences for fairness and reset mid-transfer.
module tb_rdb_pair_arb;
   import rdb_pair_arb_pkg::*;

   localparam int unsigned NP = 4;
   localparam int unsigned NC = 8;
`ifdef RDB_PAIR_ARB_COLLISION_CNT_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NC-1:0]       in_vld;
   group_data_pld_t     in_pld [NC];
   logic [NP-1:0]       out_vld;
   group_data_pld_t     out_pld [NP];
   logic [NP-1:0]       out_rdy;
   logic [NC-1:0]       ovf_err;
   logic                err_clr;
   logic                idle;
   logic [16*NP-1:0]    collision_cnt;

   int checks = 0;
   int errors = 0;

   rdb_pair_arb #(.NUM_PAIR(NP), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_pld(in_pld),
      .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy),
      .ovf_err(ovf_err), .err_clr(err_clr), .idle(idle),
      .collision_cnt(collision_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  vld;
      logic [23:0] tag;
      logic [3:0]  rdy;
      logic        clr;
      logic [3:0]  e_vld;
      logic [31:0] e_pld;
      logic [7:0]  e_ovf;
      logic        e_idle;
      logic [15:0] e_coll1;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vt [NVEC];

   function automatic vec_t mk(logic [7:0] vld, logic [23:0] tag, logic [3:0] rdy, logic clr,
                               logic [3:0] ev, logic [31:0] ep, logic [7:0] eo, logic ei,
                               logic [15:0] ec);
      vec_t v;
      v.vld = vld; v.tag = tag; v.rdy = rdy; v.clr = clr;
      v.e_vld = ev; v.e_pld = ep; v.e_ovf = eo; v.e_idle = ei; v.e_coll1 = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] vld, input logic [23:0] tag, input logic [3:0] rdy,
                        input logic clr);
      in_vld  = vld;
      for (int c = 0; c < int'(NC); c++) in_pld[c] = {tag, 8'(c)};
      out_rdy = rdy;
      err_clr = clr;
   endtask

   initial begin
      int ech [13];
      int ek  [13];
      logic [31:0] ep;

      // single beat, collision twice (rr_ptr back at 0), backpressure + overflow, error clear
      vt[0]  = mk(8'h01, 24'd1,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b0, 16'd0);
      vt[1]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h1, 32'h0100,  8'h00, 1'b0, 16'd0);
      vt[2]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b1, 16'd0);
      vt[3]  = mk(8'h0C, 24'd2,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b0, 16'd1);
      vt[4]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h2, 32'h0202,  8'h00, 1'b0, 16'd1);
      vt[5]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h2, 32'h0203,  8'h00, 1'b0, 16'd1);
      vt[6]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b1, 16'd1);
      vt[7]  = mk(8'h0C, 24'd3,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b0, 16'd2);
      vt[8]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h2, 32'h0302,  8'h00, 1'b0, 16'd2);
      vt[9]  = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h2, 32'h0303,  8'h00, 1'b0, 16'd2);
      vt[10] = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b1, 16'd2);
      vt[11] = mk(8'h01, 24'd4,  4'hE, 1'b0, 4'h0, 32'h0,     8'h00, 1'b0, 16'd2);
      vt[12] = mk(8'h01, 24'd5,  4'hE, 1'b0, 4'h1, 32'h0400,  8'h00, 1'b0, 16'd2);
      vt[13] = mk(8'h01, 24'd6,  4'hE, 1'b0, 4'h1, 32'h0400,  8'h00, 1'b0, 16'd2);
      vt[14] = mk(8'h01, 24'd7,  4'hE, 1'b0, 4'h1, 32'h0400,  8'h01, 1'b0, 16'd2);
      vt[15] = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h1, 32'h0500,  8'h01, 1'b0, 16'd2);
      vt[16] = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h1, 32'h0600,  8'h01, 1'b0, 16'd2);
      vt[17] = mk(8'h00, 24'd0,  4'hF, 1'b1, 4'h0, 32'h0,     8'h00, 1'b1, 16'd0);
      vt[18] = mk(8'h02, 24'd8,  4'hE, 1'b0, 4'h0, 32'h0,     8'h00, 1'b0, 16'd0);
      vt[19] = mk(8'h02, 24'd9,  4'hE, 1'b0, 4'h1, 32'h0801,  8'h00, 1'b0, 16'd0);
      vt[20] = mk(8'h02, 24'd10, 4'hE, 1'b0, 4'h1, 32'h0801,  8'h00, 1'b0, 16'd0);
      vt[21] = mk(8'h02, 24'd11, 4'hE, 1'b0, 4'h1, 32'h0801,  8'h02, 1'b0, 16'd0);
      vt[22] = mk(8'h02, 24'd12, 4'hE, 1'b1, 4'h1, 32'h0801,  8'h02, 1'b0, 16'd0);
      vt[23] = mk(8'h00, 24'd0,  4'hE, 1'b1, 4'h1, 32'h0801,  8'h00, 1'b0, 16'd0);
      vt[24] = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h1, 32'h0901,  8'h00, 1'b0, 16'd0);
      vt[25] = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h1, 32'h0A01,  8'h00, 1'b0, 16'd0);
      vt[26] = mk(8'h00, 24'd0,  4'hF, 1'b0, 4'h0, 32'h0,     8'h00, 1'b1, 16'd0);

      rst = 1'b1;
      drive(8'h00, 24'd0, 4'hF, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst out_vld", 64'(out_vld), 64'h0);
      for (int p = 0; p < int'(NP); p++) chk($sformatf("rst out_pld%0d", p), 64'(out_pld[p]), 64'h0);
      chk("rst ovf_err", 64'(ovf_err), 64'h0);
      chk("rst idle", 64'(idle), 64'h1);
      chk("rst collision_cnt", collision_cnt, 64'h0);
      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         drive(vt[i].vld, vt[i].tag, vt[i].rdy, vt[i].clr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_vld", i), 64'(out_vld), 64'(vt[i].e_vld));
         for (int p = 0; p < int'(NP); p++)
            if (vt[i].e_vld[p]) chk($sformatf("v%0d out_pld%0d", i, p), 64'(out_pld[p]), 64'(vt[i].e_pld));
         chk($sformatf("v%0d ovf_err", i), 64'(ovf_err), 64'(vt[i].e_ovf));
         chk($sformatf("v%0d idle", i), 64'(idle), 64'(vt[i].e_idle));
         chk($sformatf("v%0d coll1", i), 64'(collision_cnt[31:16]),
             COLL_EN ? 64'(vt[i].e_coll1) : 64'h0);
         @(negedge clk);
      end

      // fairness on pair 2: both channels every cycle for 8 cycles, one pop per cycle
      ech = '{0, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 0};
      ek  = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 0};
      for (int k = 0; k < 13; k++) begin
         drive((k < 8) ? 8'h30 : 8'h00, 24'(32 + k), 4'hF, 1'b0);
         @(posedge clk);
         #1;
         chk($sformatf("fair%0d out_vld", k), 64'(out_vld), (ech[k] != 0) ? 64'h4 : 64'h0);
         if (ech[k] != 0) begin
            ep = {24'(32 + ek[k]), 8'(ech[k])};
            chk($sformatf("fair%0d out_pld2", k), 64'(out_pld[2]), 64'(ep));
         end
         @(negedge clk);
      end
      chk("fair ovf_err", 64'(ovf_err), 64'h30);
      chk("fair coll2", 64'(collision_cnt[47:32]), COLL_EN ? 64'd8 : 64'h0);
      drive(8'h00, 24'd0, 4'hF, 1'b1);
      @(posedge clk);
      #1;
      chk("fair clr ovf_err", 64'(ovf_err), 64'h0);
      @(negedge clk);

      // reset while pair 3 holds one beat in the output and two in the FIFO
      for (int k = 0; k < 3; k++) begin
         drive(8'h40, 24'(48 + k), 4'h7, 1'b0);
         @(posedge clk);
         @(negedge clk);
      end
      chk("pre-rst out_vld", 64'(out_vld), 64'h8);
      chk("pre-rst out_pld3", 64'(out_pld[3]), 64'h3006);
      chk("pre-rst idle", 64'(idle), 64'h0);
      drive(8'h00, 24'd0, 4'h7, 1'b0);
      rst = 1'b1;
      #1;
      chk("async rst out_vld", 64'(out_vld), 64'h0);
      chk("async rst out_pld3", 64'(out_pld[3]), 64'h0);
      chk("async rst idle", 64'(idle), 64'h1);
      @(negedge clk);
      rst = 1'b0;
      drive(8'h00, 24'd0, 4'hF, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post-rst%0d out_vld", k), 64'(out_vld), 64'h0);
         chk($sformatf("post-rst%0d idle", k), 64'(idle), 64'h1);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
